// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - memory, decoder and datapath handshake bundle for cpu_sequencer
interface cpu_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ctrl;
  logic [31:0] ctrl_q;
  logic        rf_rd_en;
  logic        alu_en;
  logic        mul_start;
  logic        mul_done;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_wr_en;
  logic [4:0]  rf_waddr;

  modport master (
    output imem_req, ir, ctrl_q, rf_rd_en, alu_en, mul_start,
           dmem_req, dmem_we, rf_wr_en, rf_waddr,
    input  imem_ack, imem_rdata, ctrl, mul_done, dmem_ack
  );

  modport slave (
    input  imem_req, ir, ctrl_q, rf_rd_en, alu_en, mul_start,
           dmem_req, dmem_we, rf_wr_en, rf_waddr,
    output imem_ack, imem_rdata, ctrl, mul_done, dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer owning pc and memory handshakes
module cpu_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int MUL_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              fault,
  cpu_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MUL_WAIT = 3'd4,
    S_MEM      = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  localparam int CNT_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  state_t            cur;
  state_t            nxt;
  logic [CNT_W-1:0]  mul_cnt;
  logic [31:0]       ir_q;
  logic [31:0]       ctrl_r;
  logic              pc_step;

  // Legality is judged on the raw instruction, not on the decoder's output.
  function automatic logic is_legal(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] funct;
    op    = ins[31:26];
    funct = ins[5:0];
    case (op)
      6'd18:   is_legal = (funct == 6'd32) || (funct == 6'd34) || (funct == 6'd36) ||
                          (funct == 6'd37) || (funct == 6'd50);
      6'd19,
      6'd20:   is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:     if (run) nxt = S_FETCH;
      S_FETCH:    if (bus.imem_ack) nxt = S_DECODE;
      S_DECODE:   nxt = is_legal(ir_q) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (ctrl_r[18])     nxt = S_MUL_WAIT;
        else if (ctrl_r[0]) nxt = S_MEM;
        else                nxt = S_WB;
      end
      S_MUL_WAIT: begin
        if (bus.mul_done)             nxt = S_WB;
        else if (mul_cnt == CNT_LAST) nxt = S_HALT;
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (ctrl_r[21]) nxt = run ? S_FETCH : S_IDLE;
          else            nxt = S_WB;
        end
      end
      S_WB:       nxt = run ? S_FETCH : S_IDLE;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_IDLE;
    endcase
  end

  // A store retires on its ack; everything else retires in WB.
  assign pc_step = (cur == S_WB) || ((cur == S_MEM) && bus.dmem_ack && ctrl_r[21]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir_q    <= '0;
      ctrl_r  <= '0;
      fault   <= 1'b0;
      mul_cnt <= '0;
    end else begin
      if (pc_step) pc <= pc + ADDR_W'(4);
      if ((cur == S_FETCH) && bus.imem_ack) ir_q <= bus.imem_rdata;
      if (cur == S_DECODE) ctrl_r <= bus.ctrl;
      if ((nxt == S_HALT) && (cur != S_HALT)) fault <= 1'b1;
      if (cur == S_MUL_WAIT) mul_cnt <= mul_cnt + CNT_W'(1);
      else                   mul_cnt <= '0;
    end
  end

  assign state         = cur;
  assign bus.ir        = ir_q;
  assign bus.ctrl_q    = ctrl_r;
  assign bus.imem_req  = (cur == S_FETCH);
  assign bus.rf_rd_en  = (cur == S_DECODE);
  assign bus.alu_en    = (cur == S_EXEC);
  assign bus.mul_start = (cur == S_EXEC) && ctrl_r[18];
  assign bus.dmem_req  = (cur == S_MEM);
  assign bus.dmem_we   = (cur == S_MEM) && ctrl_r[21];
  assign bus.rf_wr_en  = (cur == S_WB);
  assign bus.rf_waddr  = ctrl_r[5:1];

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer for the MIPS-subset datapath. It fetches an instruction, presents it to the combinational control decoder, latches the resulting 32-bit control word and steps the datapath through execute, memory and writeback with per-stage enables. It sits between instruction memory, the control decoder, the register file, the ALU/multiplier and data memory. It owns the PC and all memory handshakes.

## Interface
- ADDR_W, 16, PC / memory address width
- MUL_TIMEOUT, 32, maximum cycles spent waiting for mul_done before a fault
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep issuing instructions
- pc  out  ADDR_W  current instruction address
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, drives control decoder input
- ctrl  in  32  decoder output: [21] wr, [20] muxA, [19] muxR, [18] muxM, [17:16] alu, [15:11] rs, [10:6] rt, [5:1] rd, [0] cs
- ctrl_q  out  32  control word latched in DECODE, drives datapath muxes
- rf_rd_en  out  1  register file read strobe
- alu_en  out  1  ALU result capture strobe
- mul_start  out  1  one-cycle multiplier start pulse
- mul_done  in  1  multiplier result valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load (equals ctrl_q[21])
- dmem_ack  in  1  data access complete
- rf_wr_en  out  1  register file write strobe
- rf_waddr  out  5  write address, equals ctrl_q[5:1]
- state  out  3  encoded FSM state, for debug
- fault  out  1  sticky: illegal instruction or multiplier timeout

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MUL_WAIT=4, MEM=5, WB=6, HALT=7.
- IDLE: go to FETCH when run=1.
- FETCH: assert imem_req and hold it until imem_ack=1. On the ack cycle, capture imem_rdata into ir and go to DECODE.
- DECODE: latch ctrl into ctrl_q and assert rf_rd_en.
  - Legal encodings: op=18 with funct ∈ {32,34,36,37,50}, op=19 (lw), op=20 (sw).
  - Any other encoding: set fault and go to HALT.
  - Otherwise go to EXEC.
- EXEC: assert alu_en.
  - If ctrl_q[18]=1 (mul): pulse mul_start and go to MUL_WAIT.
  - Else if ctrl_q[0]=1: go to MEM.
  - Else: go to WB.
- MUL_WAIT: wait for mul_done=1, then go to WB. A cycle counter starts at 0 on entry; reaching MUL_TIMEOUT without mul_done sets fault and goes to HALT.
- MEM: assert dmem_req and hold it until dmem_ack=1, with dmem_we=ctrl_q[21]. On ack:
  - lw: go to WB.
  - sw: pc += 4, then go to FETCH if run=1, else IDLE.
- WB: assert rf_wr_en for one cycle at rf_waddr, pc += 4, then go to FETCH if run=1, else IDLE.
- HALT: absorbing; only rst_n leaves it.
- pc arithmetic is modulo 2^ADDR_W; 2^ADDR_W−4 wraps to 0.
- run is sampled only at instruction boundaries (IDLE, end of WB, end of sw MEM). Deasserting it mid-instruction never aborts the instruction.
- All stage strobes are mutually exclusive and asserted only in their own state.

## Timing
- Reset values:
  - state=IDLE, pc=0, ir=0, ctrl_q=0, fault=0.
  - All req/en/start/we outputs 0; rf_waddr=0.
- Assertion of rst_n mid-operation drops imem_req/dmem_req immediately (asynchronous) and returns to IDLE; no write strobe is emitted.
- Minimum latency with same-cycle ack (req high and ack high in the same cycle):
  - ALU R-type: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - mul: 4 + N cycles, where N ≥ 1 is the number of MUL_WAIT cycles.
- ack arriving while its req is 0 is ignored.
- mul_done high in the same cycle as mul_start is ignored; it is sampled from the first MUL_WAIT cycle.
- Outputs are registered state decodes; ir, ctrl_q and pc change only on clock edges.

## Test plan
- Reset, run=1, imem returns add (op 18, funct 32, rd=3) with ack in the same cycle -> state sequence 1,2,3,6,1; rf_wr_en pulses once with rf_waddr=3; pc=4.
- lw (op 19, rt=5), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with rf_waddr=5; sw (op 20) -> dmem_we=1, no rf_wr_en, pc advances by 4.
- mul (funct 50), mul_done after 2 cycles -> one mul_start pulse, WB follows; repeat with mul_done never asserted -> fault=1 and state=7 after MUL_TIMEOUT cycles.
- Illegal op 0x3F, and op 18 with funct 0 -> fault=1, state=7, no rf_wr_en/dmem_req; remains halted until rst_n.
- run dropped during EXEC of add -> instruction completes, state=0 after WB; pc preloaded near 0xFFFC (ADDR_W=16) -> pc wraps to 0.
- rst_n asserted mid-MEM with dmem_req high -> dmem_req=0 immediately, state=0, pc=0, fault=0.
